// File: rtl/mem_pkg.sv
// Shared encodings and constants for the memory responder and its RAM.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int   CNT_W      = 4;
    localparam int   WORD_BYTES = 4;
    localparam logic ERR_ADDR   = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Word-organised single-port RAM with per-byte write enables and a registered read.
module mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          write,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    import mem_pkg::*;

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (write) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// address checking and a held response until the core takes it.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    import mem_pkg::*;

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        wstrb_q;
    logic              err_q, rd_ok;
    logic [31:0]       offset;
    logic              addr_err;
    logic [AW-1:0]     word_idx;
    logic              ram_en;
    logic [31:0]       ram_rdata;

    // Range check runs on the full 32-bit offset; only then is it truncated to an index.
    assign offset   = addr_q - BASE_ADDR;
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                      ((offset >> 2) >= 32'(DEPTH_WORDS));
    assign word_idx = offset[AW+1:2];

    // Gating with reset keeps a write from landing on the edge that aborts it.
    assign ram_en = (state == EXEC) && !addr_err && reset;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? WAIT : EXEC;
            end
            WAIT: if (cnt == '0) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) cnt <= WAIT_LOAD;
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                EXEC: begin
                    err_q <= addr_err ? ERR_ADDR : 1'b0;
                    rd_ok <= !write_q && !addr_err;
                end
                RESP: if (resp_ready) begin
                    err_q <= 1'b0;
                    rd_ok <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    assign resp_rdata = rd_ok ? ram_rdata : 32'h0;
    assign resp_err   = err_q;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .write(write_q),
        .be   (wstrb_q),
        .addr (word_idx),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule
